// File: rtl/tx_arbiter.sv
// Round-robin scheduler sharing one serial byte transmitter between NUM_REQ sources.
// Optional feature: define TX_ARB_TIMEOUT_EN for the baud-tick watchdog driving err.
module tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int BAUD_DIV      = 5208,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 baud_tick,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_finish,
  output logic                 err
);

  localparam int CW = $clog2(BAUD_DIV);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BAUD_DIV < 2 || TIMEOUT_TICKS < 1) begin : g_param_check
    $error("tx_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_ACC,
    S_WAIT_DONE,
    S_ACK
  } state_t;

  state_t              state;
  logic [CW-1:0]       baud_cnt;
  logic                tick_d;
  logic                timeout;

  logic                hi_found, lo_found, pick_found;
  logic [2:0]          hi_id, lo_id, pick_id;
  logic [7:0]          hi_data, lo_data, pick_data;
  logic [NUM_REQ-1:0]  grant_onehot;

  // Free-running divider; baud_tick is registered so it is high exactly
  // while baud_cnt sits at BAUD_DIV-1.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      baud_tick <= 1'b0;
      tick_d    <= 1'b0;
    end else begin
      baud_cnt  <= (baud_cnt == CW'(BAUD_DIV - 1)) ? '0 : baud_cnt + 1'b1;
      baud_tick <= (baud_cnt == CW'(BAUD_DIV - 2));
      tick_d    <= baud_tick;
    end
  end

  // Round-robin pick: lowest requester above grant_id wins, otherwise the lowest
  // at or below it. Descending scan so the last hit is the lowest index.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    hi_found     = 1'b0;
    lo_found     = 1'b0;
    hi_id        = '0;
    lo_id        = '0;
    hi_data      = '0;
    lo_data      = '0;
    grant_onehot = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (3'(i) > grant_id) begin
          hi_found = 1'b1;
          hi_id    = 3'(i);
          hi_data  = req_data[8*i +: 8];
        end else begin
          lo_found = 1'b1;
          lo_id    = 3'(i);
          lo_data  = req_data[8*i +: 8];
        end
      end
      if (3'(i) == grant_id) grant_onehot[i] = 1'b1;
    end
    pick_found = hi_found | lo_found;
    pick_id    = hi_found ? hi_id   : lo_id;
    pick_data  = hi_found ? hi_data : lo_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      grant_id <= 3'(NUM_REQ - 1);
      tx_start <= 1'b0;
      tx_data  <= '0;
      ack      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_id;
            tx_data  <= pick_data;
            busy     <= 1'b1;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          tx_start <= 1'b1;
          state    <= S_WAIT_ACC;
        end
        S_WAIT_ACC: begin
          if (timeout) begin
            tx_start <= 1'b0;
            ack      <= grant_onehot;
            state    <= S_ACK;
          end else if (tick_d && !tx_finish) begin
            // Transmitter sampled isStart on the tick and dropped isFinish.
            tx_start <= 1'b0;
            state    <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (tx_finish || timeout) begin
            tx_start <= 1'b0;
            ack      <= grant_onehot;
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          busy  <= 1'b0;
          ack   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic [TW-1:0] to_cnt;
  logic          waiting;

  assign waiting = (state == S_WAIT_ACC) || (state == S_WAIT_DONE);
  assign timeout = waiting && baud_tick && (to_cnt == TW'(TIMEOUT_TICKS - 1));

  // Watchdog spans acceptance and the frame itself; restarted at every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state == S_GRANT) begin
        to_cnt <= '0;
      end else if (waiting && baud_tick) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with a behavioural start/8N/even-parity/stop transmitter.
// Runs the timeout scenario only when TX_ARB_TIMEOUT_EN is defined.
module tb_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int BAUD_DIV      = 4;
  localparam int TIMEOUT_TICKS = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy;
  logic [2:0]           grant_id;
  logic                 baud_tick;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_finish = 1'b1;
  logic                 err;

  always #5 clk = ~clk;

  tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .BAUD_DIV     (BAUD_DIV),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .baud_tick(baud_tick),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_finish(tx_finish),
    .err      (err)
  );

  // Transmitter model: accepts isStart on a baud tick, sends start, 8 data bits
  // LSB first, even parity, stop, and raises isFinish on the 11th tick after accept.
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [9:0]  m_sh = '0;
  logic [10:0] line_bits = '0;
  logic        stall = 1'b0;
  logic        abort_m = 1'b0;

  always @(posedge clk) begin
    if (abort_m) begin
      m_busy    <= 1'b0;
      tx_finish <= 1'b1;
    end else if (baud_tick) begin
      if (!m_busy) begin
        if (tx_start) begin
          m_busy    <= 1'b1;
          tx_finish <= 1'b0;
          m_sh      <= {1'b1, ^tx_data, tx_data};
          m_cnt     <= 0;
          line_bits <= '0;
        end
      end else if (!stall) begin
        if (m_cnt < 10) begin
          line_bits[m_cnt+1] <= m_sh[m_cnt];
          m_cnt              <= m_cnt + 1;
        end else begin
          m_busy    <= 1'b0;
          tx_finish <= 1'b1;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag, input logic [NUM_REQ-1:0] exp, input int budget);
    int cyc;
    cyc = 0;
    while (ack == '0 && cyc < budget) begin
      step();
      cyc++;
    end
    check(tag, 32'(ack), 32'(exp));
  endtask

  task automatic wait_start_fall(input int budget);
    int cyc;
    cyc = 0;
    while (!tx_start && cyc < budget) begin step(); cyc++; end
    while (tx_start && cyc < budget) begin step(); cyc++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0]       tick_pat;
    logic              any;
    int                fin_cyc, ack_cyc, cyc, nack, low;
    logic              seen_low;
    logic [NUM_REQ-1:0] av;
    logic [2:0]        exp_ids [5];
    logic [7:0]        exp_dat [5];

    exp_ids = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    // Reset values
    #12;
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), NUM_REQ - 1);
    check("rst_baud_tick", 32'(baud_tick), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_err", 32'(err), 0);

    // Baud divider: high in the 4th, 8th, 12th cycle after release
    @(negedge clk);
    rst_n = 1'b1;
    tick_pat = '0;
    any = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step();
      tick_pat[n] = baud_tick;
      any |= tx_start;
    end
    check("baud_tick_pattern", 32'(tick_pat), 32'h444);
    check("no_tx_start_when_idle", 32'(any), 0);

    // Single requester, byte 0xA5
    req = 4'b0001;
    req_data[7:0] = 8'hA5;
    step();
    check("a5_tx_data", 32'(tx_data), 32'hA5);
    check("a5_grant_id", 32'(grant_id), 0);
    check("a5_busy", 32'(busy), 1);
    check("a5_tx_start_c1", 32'(tx_start), 0);
    step();
    check("a5_tx_start_c2", 32'(tx_start), 1);
    fin_cyc = -1;
    ack_cyc = -1;
    seen_low = 1'b0;
    av = '0;
    for (int c = 0; c < 300 && ack_cyc < 0; c++) begin
      step();
      if (!tx_finish) seen_low = 1'b1;
      else if (seen_low && fin_cyc < 0) fin_cyc = c;
      if (ack != '0) begin
        ack_cyc = c;
        av = ack;
      end
    end
    check("a5_ack_after_finish", 32'(ack_cyc - fin_cyc), 1);
    check("a5_ack_value", 32'(av), 32'b0001);
    check("a5_busy_in_ack", 32'(busy), 1);
    check("a5_line_bits", 32'(line_bits), 32'b10101001010);
    req = '0;
    step();
    check("a5_ack_cleared", 32'(ack), 0);
    check("a5_busy_low", 32'(busy), 0);

    // All four requesting: round-robin 0,1,2,3,0 from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 4'b1111;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int f = 0; f < 5; f++) begin
      cyc = 0;
      low = 0;
      while (!busy && cyc < 50) begin
        step();
        cyc++;
        low++;
      end
      if (f > 0) check($sformatf("rr_busy_gap_%0d", f), 32'(low), 1);
      check($sformatf("rr_grant_%0d", f), 32'(grant_id), 32'(exp_ids[f]));
      check($sformatf("rr_data_%0d", f), 32'(tx_data), 32'(exp_dat[f]));
      cyc = 0;
      nack = 0;
      av = '0;
      while (busy && cyc < 300) begin
        if (ack != '0) begin
          nack++;
          av = ack;
          if (f == 4) req = '0;
        end
        step();
        cyc++;
      end
      check($sformatf("rr_ack_count_%0d", f), 32'(nack), 1);
      check($sformatf("rr_ack_value_%0d", f), 32'(av), 32'(1) << exp_ids[f]);
    end

    // Requester 2 drops req mid-frame: frame completes, ack still pulsed, no regrant
    req = 4'b0100;
    req_data[23:16] = 8'h5C;
    step();
    check("drop_grant_id", 32'(grant_id), 2);
    wait_start_fall(200);
    for (int i = 0; i < 8; i++) step();
    req = '0;
    wait_ack("drop_ack", 4'b0100, 300);
    check("drop_line_bits", 32'(line_bits), 32'b10010111000);
    step();
    any = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      any |= busy;
    end
    check("drop_no_regrant", 32'(any), 0);

    // Reset during WAIT_DONE: immediate return to reset values, no ack
    req = 4'b0001;
    req_data[7:0] = 8'h3C;
    step();
    check("mrst_grant_id", 32'(grant_id), 0);
    wait_start_fall(200);
    for (int i = 0; i < 6; i++) step();
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_tx_start", 32'(tx_start), 0);
    check("mrst_grant_id_rst", 32'(grant_id), NUM_REQ - 1);
    check("mrst_tx_data", 32'(tx_data), 0);
    check("mrst_ack", 32'(ack), 0);
    check("mrst_baud_tick", 32'(baud_tick), 0);
    step();
    step();
    rst_n = 1'b1;
    any = 1'b0;
    cyc = 0;
    while (!tx_finish && cyc < 300) begin
      step();
      any |= (ack != '0);
      cyc++;
    end
    check("mrst_xmtr_drained", 32'(tx_finish), 1);
    check("mrst_no_ack", 32'(any), 0);
    req = 4'b0010;
    req_data[15:8] = 8'h7E;
    step();
    check("mrst_next_grant", 32'(grant_id), 1);
    check("mrst_next_data", 32'(tx_data), 32'h7E);
    wait_ack("mrst_next_ack", 4'b0010, 300);
    req = '0;
    step();
    step();

`ifdef TX_ARB_TIMEOUT_EN
    // Transmitter stuck with isFinish low: watchdog releases the requester
    check("to_err_clear", 32'(err), 0);
    stall = 1'b1;
    req = 4'b0001;
    step();
    check("to_grant_id", 32'(grant_id), 0);
    wait_ack("to_ack", 4'b0001, 300);
    check("to_err_set", 32'(err), 1);
    req = '0;
    step();
    check("to_busy_released", 32'(busy), 0);
    abort_m = 1'b1;
    step();
    abort_m = 1'b0;
    stall = 1'b0;
    req = 4'b0010;
    step();
    check("to_next_grant", 32'(grant_id), 1);
    wait_ack("to_next_ack", 4'b0010, 300);
    check("to_err_sticky", 32'(err), 1);
    req = '0;
    step();
`else
    check("err_tied_low", 32'(err), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
